// File: rtl/video_pkg.sv
// Shared constants and fetch-sequencer state encoding for the VRAM scanline fetcher.
package video_pkg;
    localparam int VRAM_AW            = 13;
    localparam int PIX_PER_WORD       = 16;
    localparam int DEF_WORDS_PER_LINE = 640 / PIX_PER_WORD;
    localparam int DEF_LINES          = 200;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_H = 2'd1,
        FETCH  = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/vram_scan_fetcher_if.sv
// Wishbone read bus towards the VRAM B port plus the pixel-word stream to the shifter.
interface vram_scan_fetcher_if;
    import video_pkg::*;

    logic [VRAM_AW-1:0] adr;
    logic               cyc;
    logic               stb;
    logic               we;
    logic [1:0]         sel;
    logic               ack;
    logic [15:0]        dat;
    logic [15:0]        pix_dat;
    logic               pix_vld;
    logic               pix_rdy;

    modport master (
        output adr, cyc, stb, we, sel, pix_dat, pix_vld,
        input  ack, dat, pix_rdy
    );

    modport slave (
        input  adr, cyc, stb, we, sel, pix_dat, pix_vld,
        output ack, dat, pix_rdy
    );
endinterface

// File: rtl/scan_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word is presented combinationally.
module scan_fifo #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      free
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign free    = (AW+1)'(DEPTH) - cnt;
    assign do_pop  = pop & ~empty;
    // A pop frees the head slot in the same edge, so push is allowed even when full.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/vram_scan_fetcher.sv
// Video-refresh DMA sequencer: fetches one scanline of VRAM words per HSTART into a FIFO
// that the pixel shifter drains.
module vram_scan_fetcher
    import video_pkg::*;
#(
    parameter int                 WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int                 LINES          = DEF_LINES,
    parameter logic [VRAM_AW-1:0] BASE_ADR       = '0,
    parameter int                 FIFO_AW        = 3
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic                VSYNC_I,
    input  logic                HSTART_I,
    vram_scan_fetcher_if.master bus,
    output logic [7:0]          LINE_O,
    output logic                LATE_O
);
    localparam int CW = $clog2(WORDS_PER_LINE + 1);

    fetch_state_t     state;
    logic [CW-1:0]    count;
    logic             accept;
    logic             pop_eff;
    logic             last;
    logic             room;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] free;
    logic [FIFO_AW+1:0] free_nxt;

    assign accept  = bus.ack & bus.stb;
    assign pop_eff = bus.pix_rdy & ~fifo_empty;
    assign last    = (count == CW'(WORDS_PER_LINE - 1));
    // Room is judged on the fill level after this edge; two free slots cover the read in flight.
    assign free_nxt = {1'b0, free} + (FIFO_AW+2)'(pop_eff) - (FIFO_AW+2)'(accept);
    assign room     = ~fifo_full & (free_nxt >= (FIFO_AW+2)'(2));

    assign bus.we      = 1'b0;
    assign bus.sel     = bus.stb ? 2'b11 : 2'b00;
    assign bus.pix_vld = ~fifo_empty;

    scan_fifo #(
        .WIDTH (16),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (CLK_I),
        .rst   (RST_I),
        .push  (accept),
        .pop   (bus.pix_rdy),
        .flush (VSYNC_I),
        .din   (bus.dat),
        .dout  (bus.pix_dat),
        .full  (fifo_full),
        .empty (fifo_empty),
        .free  (free)
    );

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state   <= IDLE;
            bus.adr <= BASE_ADR;
            bus.cyc <= 1'b0;
            bus.stb <= 1'b0;
            count   <= '0;
            LINE_O  <= '0;
            LATE_O  <= 1'b0;
        end else begin
            LATE_O <= HSTART_I & (state == FETCH) & ~VSYNC_I;
            if (VSYNC_I) begin
                state   <= WAIT_H;
                bus.adr <= BASE_ADR;
                bus.cyc <= 1'b0;
                bus.stb <= 1'b0;
                count   <= '0;
                LINE_O  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        bus.cyc <= 1'b0;
                        bus.stb <= 1'b0;
                    end
                    WAIT_H: begin
                        if (HSTART_I) begin
                            state   <= FETCH;
                            count   <= '0;
                            bus.cyc <= room;
                            bus.stb <= room;
                        end
                    end
                    FETCH: begin
                        if (accept) begin
                            bus.adr <= bus.adr + VRAM_AW'(1);
                            count   <= count + CW'(1);
                        end
                        if (accept && last) begin
                            bus.cyc <= 1'b0;
                            bus.stb <= 1'b0;
                            if (LINE_O == 8'(LINES - 1)) begin
                                state <= IDLE;
                            end else begin
                                state  <= WAIT_H;
                                LINE_O <= LINE_O + 8'd1;
                            end
                        end else begin
                            bus.cyc <= room;
                            bus.stb <= room;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vram_scan_fetcher.sv
// Directed bench for vram_scan_fetcher: default frame plus a wrapping 1-line frame instance.
module tb_vram_scan_fetcher;
    import video_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync_a = 1'b0, hstart_a = 1'b0;
    logic       vsync_b = 1'b0, hstart_b = 1'b0;
    logic [7:0] line_a, line_b;
    logic       late_a, late_b;

    vram_scan_fetcher_if bus_a ();
    vram_scan_fetcher_if bus_b ();

    always #5 clk = ~clk;

    vram_scan_fetcher dut_a (
        .CLK_I(clk), .RST_I(rst), .VSYNC_I(vsync_a), .HSTART_I(hstart_a),
        .bus(bus_a), .LINE_O(line_a), .LATE_O(late_a)
    );

    vram_scan_fetcher #(.BASE_ADR(13'd8180), .LINES(1)) dut_b (
        .CLK_I(clk), .RST_I(rst), .VSYNC_I(vsync_b), .HSTART_I(hstart_b),
        .bus(bus_b), .LINE_O(line_b), .LATE_O(late_b)
    );

    function automatic logic [15:0] vram_word(input logic [12:0] a);
        return {a[4:0], a[12:2]} ^ 16'hC3A5;
    endfunction

    // VRAM B-port model: acks every other cycle while STB is held.
    always @(posedge clk) begin
        if (rst) begin
            bus_a.ack <= 1'b0;
            bus_b.ack <= 1'b0;
        end else begin
            bus_a.ack <= bus_a.stb & ~bus_a.ack;
            bus_b.ack <= bus_b.stb & ~bus_b.ack;
        end
        bus_a.dat <= vram_word(bus_a.adr);
        bus_b.dat <= vram_word(bus_b.adr);
    end

    int          acks_a = 0, acks_b = 0, late_cnt_a = 0;
    logic [12:0] adr_log_a[$], adr_log_b[$];
    logic [15:0] pop_log_a[$], pop_log_b[$];

    always @(negedge clk) begin
        if (bus_a.ack && bus_a.stb) begin
            acks_a <= acks_a + 1;
            adr_log_a.push_back(bus_a.adr);
        end
        if (bus_b.ack && bus_b.stb) begin
            acks_b <= acks_b + 1;
            adr_log_b.push_back(bus_b.adr);
        end
        if (bus_a.pix_vld && bus_a.pix_rdy) pop_log_a.push_back(bus_a.pix_dat);
        if (bus_b.pix_vld && bus_b.pix_rdy) pop_log_b.push_back(bus_b.pix_dat);
        if (late_a) late_cnt_a <= late_cnt_a + 1;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_line(input bit sel_b, input int budget, output bit done);
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((sel_b ? dut_b.state : dut_a.state) != FETCH) begin
                done = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    function automatic int adr_errs(input bit sel_b, input int base, input int n, input int start);
        int e = 0;
        for (int i = 0; i < n; i++) begin
            logic [12:0] exp_adr = 13'((start + i) % 8192);
            logic [12:0] got_adr = sel_b ? adr_log_b[base + i] : adr_log_a[base + i];
            if (got_adr !== exp_adr) e++;
        end
        return e;
    endfunction

    function automatic int dat_errs(input bit sel_b, input int base, input int n, input int start);
        int e = 0;
        for (int i = 0; i < n; i++) begin
            logic [15:0] exp_dat = vram_word(13'((start + i) % 8192));
            logic [15:0] got_dat = sel_b ? pop_log_b[base + i] : pop_log_a[base + i];
            if (got_dat !== exp_dat) e++;
        end
        return e;
    endfunction

    initial begin
        int  ab, pb, kb, lb, to_cnt;
        bit  done;

        bus_a.pix_rdy = 1'b1;
        bus_b.pix_rdy = 1'b1;
        rst = 1'b1;
        tick(3);
        check("rst_state", dut_a.state, IDLE);
        check("rst_adr", bus_a.adr, 0);
        check("rst_cyc", bus_a.cyc, 0);
        check("rst_stb", bus_a.stb, 0);
        check("rst_we", bus_a.we, 0);
        check("rst_sel", bus_a.sel, 0);
        check("rst_vld", bus_a.pix_vld, 0);
        check("rst_dat", bus_a.pix_dat, 0);
        check("rst_line", line_a, 0);
        check("rst_late", late_a, 0);
        check("rst_adr_b", bus_b.adr, 8180);
        rst = 1'b0;
        tick(2);

        // Line 0 with the shifter always ready.
        vsync_a = 1'b1; tick(1); vsync_a = 1'b0;
        check("vsync_state", dut_a.state, WAIT_H);
        tick(2);
        ab = adr_log_a.size(); pb = pop_log_a.size(); kb = acks_a;
        hstart_a = 1'b1; tick(1); hstart_a = 1'b0;
        check("stb_after_hstart", bus_a.stb, 1);
        check("sel_during_stb", bus_a.sel, 3);
        wait_line(1'b0, 300, done);
        check("l0_done", done, 1);
        tick(5);
        check("l0_acks", acks_a - kb, 40);
        check("l0_adr_errs", adr_errs(1'b0, ab, 40, 0), 0);
        check("l0_pops", pop_log_a.size() - pb, 40);
        check("l0_dat_errs", dat_errs(1'b0, pb, 40, 0), 0);
        check("l0_state", dut_a.state, WAIT_H);
        check("l0_line", line_a, 1);
        check("l0_stb_idle", bus_a.stb, 0);

        // Line 1 with a stalled shifter: fetch must pause and resume losslessly.
        bus_a.pix_rdy = 1'b0;
        ab = adr_log_a.size(); pb = pop_log_a.size(); kb = acks_a;
        hstart_a = 1'b1; tick(1); hstart_a = 1'b0;
        tick(40);
        check("stall_pushes", acks_a - kb, 7);
        check("stall_stb", bus_a.stb, 0);
        check("stall_fill_le_depth", dut_a.u_fifo.cnt <= 8, 1);
        check("stall_vld", bus_a.pix_vld, 1);
        check("stall_head", bus_a.pix_dat, vram_word(13'd40));
        bus_a.pix_rdy = 1'b1;
        wait_line(1'b0, 300, done);
        check("l1_done", done, 1);
        tick(10);
        check("l1_acks", acks_a - kb, 40);
        check("l1_adr_errs", adr_errs(1'b0, ab, 40, 40), 0);
        check("l1_pops", pop_log_a.size() - pb, 40);
        check("l1_dat_errs", dat_errs(1'b0, pb, 40, 40), 0);
        check("l1_line", line_a, 2);

        // Line 2 with a second HSTART while fetching.
        ab = adr_log_a.size(); kb = acks_a;
        hstart_a = 1'b1; tick(1); hstart_a = 1'b0;
        tick(9);
        lb = late_cnt_a;
        check("late_idle", late_a, 0);
        hstart_a = 1'b1; tick(1); hstart_a = 1'b0;
        check("late_pulse", late_a, 1);
        tick(1);
        check("late_clear", late_a, 0);
        wait_line(1'b0, 300, done);
        check("l2_done", done, 1);
        tick(5);
        check("l2_acks", acks_a - kb, 40);
        check("l2_late_cnt", late_cnt_a - lb, 1);
        check("l2_adr_errs", adr_errs(1'b0, ab, 40, 80), 0);
        check("l2_line", line_a, 3);

        // Remaining lines of the frame.
        ab = adr_log_a.size(); pb = pop_log_a.size(); kb = acks_a;
        to_cnt = 0;
        for (int l = 3; l < 200; l++) begin
            hstart_a = 1'b1; tick(1); hstart_a = 1'b0;
            wait_line(1'b0, 300, done);
            if (!done) to_cnt++;
        end
        tick(5);
        check("frame_timeouts", to_cnt, 0);
        check("frame_acks", acks_a - kb, 197 * 40);
        check("frame_adr_errs", adr_errs(1'b0, ab, 197 * 40, 120), 0);
        check("frame_last_adr", adr_log_a[adr_log_a.size() - 1], 7999);
        check("frame_dat_errs", dat_errs(1'b0, pb, 197 * 40, 120), 0);
        check("frame_state", dut_a.state, IDLE);
        check("frame_line", line_a, 199);
        kb = acks_a;
        hstart_a = 1'b1; tick(1); hstart_a = 1'b0;
        tick(20);
        check("idle_hstart_acks", acks_a - kb, 0);
        check("idle_hstart_cyc", bus_a.cyc, 0);

        // Abort at word 17 with a few words buffered.
        vsync_a = 1'b1; tick(1); vsync_a = 1'b0;
        tick(2);
        kb = acks_a;
        hstart_a = 1'b1; tick(1); hstart_a = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (acks_a - kb >= 14) bus_a.pix_rdy = 1'b0;
            if (acks_a - kb >= 17) break;
            tick(1);
        end
        check("abort_word", acks_a - kb, 17);
        check("abort_pre_vld", bus_a.pix_vld, 1);
        vsync_a = 1'b1; tick(1); vsync_a = 1'b0;
        check("abort_cyc", bus_a.cyc, 0);
        check("abort_stb", bus_a.stb, 0);
        check("abort_vld", bus_a.pix_vld, 0);
        check("abort_adr", bus_a.adr, 0);
        check("abort_line", line_a, 0);
        check("abort_state", dut_a.state, WAIT_H);
        kb = acks_a;
        tick(4);
        check("abort_stale_ack", acks_a - kb, 0);
        check("abort_adr_hold", bus_a.adr, 0);
        bus_a.pix_rdy = 1'b1;
        tick(2);
        ab = adr_log_a.size(); pb = pop_log_a.size(); kb = acks_a;
        hstart_a = 1'b1; tick(1); hstart_a = 1'b0;
        wait_line(1'b0, 300, done);
        check("restart_done", done, 1);
        tick(5);
        check("restart_acks", acks_a - kb, 40);
        check("restart_adr_errs", adr_errs(1'b0, ab, 40, 0), 0);
        check("restart_dat_errs", dat_errs(1'b0, pb, 40, 0), 0);
        check("restart_line", line_a, 1);

        // Wrapping 1-line frame on the second instance.
        vsync_b = 1'b1; tick(1); vsync_b = 1'b0;
        tick(2);
        ab = adr_log_b.size(); pb = pop_log_b.size(); kb = acks_b;
        hstart_b = 1'b1; tick(1); hstart_b = 1'b0;
        wait_line(1'b1, 300, done);
        check("wrap_done", done, 1);
        tick(5);
        check("wrap_acks", acks_b - kb, 40);
        check("wrap_first", adr_log_b[ab], 8180);
        check("wrap_top", adr_log_b[ab + 11], 8191);
        check("wrap_zero", adr_log_b[ab + 12], 0);
        check("wrap_last", adr_log_b[ab + 39], 27);
        check("wrap_adr_errs", adr_errs(1'b1, ab, 40, 8180), 0);
        check("wrap_dat_errs", dat_errs(1'b1, pb, 40, 8180), 0);
        check("wrap_state", dut_b.state, IDLE);
        check("wrap_line", line_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
